reg_wb_scheduler: RTL and testbench
===================================

# reg_wb_scheduler

Writeback scheduler for the MIPS register file's single write port. Up to `NREQ` writeback sources (ALU, load unit, mult/div unit) compete for the port, and a round-robin arbiter picks one per cycle. A per-register pending-write scoreboard tracks reserved long-latency destinations and flags read-after-write hazards for the two read addresses. The block sits between the execute/memory units and the register file write port (`write`, `write_addr`, `data_in`).

## Interface
Parameters:
- `NREQ`, default 3: number of writeback requesters (2..4).
- `DATA_W`, default 32: writeback data width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, NREQ: requester i holds a writeback.
- `req_addr`, in, 5*NREQ: destination register of requester i, in slice [5i+4:5i].
- `req_data`, in, DATA_W*NREQ: writeback data of requester i, in slice i.
- `req_ready`, out, NREQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsv_valid`, in, 1: reserve destination `rsv_addr` for an issued long-latency op.
- `rsv_addr`, in, 5: register to reserve.
- `chk_addr_a`, in, 5: read-port A address to hazard-check.
- `chk_addr_b`, in, 5: read-port B address to hazard-check.
- `hazard`, out, 1: `chk_addr_a` or `chk_addr_b` has a pending write.
- `rf_write`, out, 1: drives the register file write enable.
- `rf_write_addr`, out, 5: drives the register file write address.
- `rf_data`, out, DATA_W: drives the register file write data.
- `rsv_overflow`, out, 1: sticky flag, set when a reservation is dropped.

## Operation
Arbitration:
- A rotating pointer `ptr` (0..NREQ-1) selects the search start.
- The winner is the first i with `req_valid[i]`, searching ptr, ptr+1, … with wrap mod NREQ.
- `req_ready` is one-hot on the winner and all-zero when no requester is valid. It is combinational from `req_valid` and `ptr`.
- On a grant, `ptr` becomes winner+1 mod NREQ. With no grant, `ptr` holds.
- A requester must hold `req_valid`, `req_addr` and `req_data` stable until it is granted.

Output stage:
- On the edge after a grant, register `rf_write`, `rf_write_addr` and `rf_data` from the winner.
- `rf_write` is 0 if there was no grant or the winner's `req_addr` is 0.
- A write to register 0 is still accepted, which consumes the grant and advances `ptr`, but it is never forwarded to the register file.

Scoreboard:
- Each register r (1..31) has a 2-bit pending count `cnt[r]`. Register 0 is never tracked.
- Increment: `rsv_valid` with `rsv_addr != 0` and `cnt < 3`.
- Decrement: `rf_write` with `rf_write_addr == r` and `cnt[r] > 0`. This happens on the same edge at which the register file captures the data.
- Increment and decrement on the same register in the same cycle leave the count unchanged.
- A writeback to a register with count 0 is an untracked single-cycle op. It causes no count change and no underflow.
- A reservation when the count is already 3 is dropped and sets `rsv_overflow`. The flag is cleared only by `reset`.
- `hazard = (chk_addr_a != 0 & cnt[chk_addr_a] != 0) | (chk_addr_b != 0 & cnt[chk_addr_b] != 0)`. It is combinational from the registered counts. There is no bypass, so a reservation made this cycle affects `hazard` from the next cycle.

Reset:
- All counts, `ptr`, `rf_write`, `rf_write_addr`, `rf_data` and `rsv_overflow` reset to 0.
- While `reset` is high, `req_ready` is forced to 0 and `hazard` to 0.
- A transfer pending in the output stage when reset asserts is discarded. `rf_write` is 0 after that edge.

## Timing
- Grant latency is 0 cycles: `req_ready` is valid in the same cycle as `req_valid`.
- Write latency: a grant at edge N gives `rf_write = 1` during cycle N+1, the register file write and count decrement at edge N+1, and `hazard` deasserts in cycle N+2 if the count reached 0.
- Throughput is one writeback per cycle. Under persistent requests from all requesters, each is granted at least once every NREQ cycles.
- A requester re-asserting immediately after its grant waits behind the other valid requesters.

## Test plan
- Reset, then all `req_valid = 0` -> `req_ready = 000`, `rf_write = 0`, `hazard = 0` for 5 cycles.
- `req_valid = 111` held for 6 cycles (NREQ = 3) -> grant order 0,1,2,0,1,2. `rf_write_addr` follows the corresponding `req_addr` one cycle later.
- Reserve r8 at cycle 0, set `chk_addr_a = 8` -> `hazard = 1` from cycle 1. At cycle 3, requester 2 writes r8 with 0xDEADBEEF -> `rf_write = 1`, `rf_data = 0xDEADBEEF` in cycle 4, and `hazard = 0` in cycle 5.
- Reserve r5 four times -> `cnt = 3`, `rsv_overflow = 1`. Three writebacks to r5 -> `hazard` is still 1 after two writebacks and 0 after the third.
- Reserve r9 in the same cycle that `rf_write` targets r9 with `cnt[r9] = 1` -> count stays 1 and `hazard` stays 1.
- Requester 1 writes r0 with 0x1234 -> `req_ready[1] = 1`, `rf_write = 0` next cycle, and `ptr` advances to 2. A mid-transfer `reset` -> `rf_write = 0` after the edge.

Source files
------------

// File: rtl/reg_wb_scheduler.sv
// ---------------------------------------------------------------------------
// reg_wb_scheduler
//
// Writeback scheduler for the register file's single write port. Up to NREQ
// writeback sources compete for the port; a round-robin arbiter grants one
// per cycle and the winner is registered into the write-port output stage.
// A per-register pending-write scoreboard counts reserved long-latency
// destinations and flags read-after-write hazards on the two read addresses.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req_valid[i]      requester i holds a writeback
//   req_addr          destination register of requester i in [5i+4:5i]
//   req_data          writeback data of requester i in slice i
//   req_ready         one-hot grant (combinational from req_valid and ptr)
//   rsv_valid/addr    reserve a destination for an issued long-latency op
//   chk_addr_a/b      read-port addresses checked against the scoreboard
//   hazard            a checked address has a pending write
//   rf_write          register file write enable
//   rf_write_addr     register file write address
//   rf_data           register file write data
//   rsv_overflow      sticky: a reservation was dropped (count already 3)
// ---------------------------------------------------------------------------
module reg_wb_scheduler #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [5*NREQ-1:0]      req_addr,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   rsv_valid,
  input  logic [4:0]             rsv_addr,
  input  logic [4:0]             chk_addr_a,
  input  logic [4:0]             chk_addr_b,
  output logic                   hazard,
  output logic                   rf_write,
  output logic [4:0]             rf_write_addr,
  output logic [DATA_W-1:0]      rf_data,
  output logic                   rsv_overflow
);

  // Pointer width, plus one spare bit so the wrap-around sum cannot overflow.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = PW + 1;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     cand;
  logic [SW-1:0]     candSum;
  logic [SW-1:0]     nextSum;
  logic              anyGrant;

  logic [4:0]        addrArr [NREQ];
  logic [DATA_W-1:0] dataArr [NREQ];
  logic [4:0]        winAddr;
  logic [DATA_W-1:0] winData;

  logic              rf_write_q;
  logic [4:0]        rf_write_addr_q;
  logic [DATA_W-1:0] rf_data_q;

  logic [1:0]        cnt_q [32];
  logic [1:0]        cnt_d [32];
  logic [31:0]       incVec;
  logic [31:0]       decVec;
  logic              ovf_q, ovf_d;

  // Unpack the flat requester buses into per-requester arrays so the
  // winner can be selected with a plain array index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addrArr[i] = req_addr[5*i +: 5];
      dataArr[i] = req_data[DATA_W*i +: DATA_W];
    end
  end

  // Round-robin search: visit ptr, ptr+1, ... modulo NREQ and take the first
  // valid requester. The explicit subtract keeps the wrap correct when NREQ
  // is not a power of two. Reset suppresses any grant.
  always_comb begin
    anyGrant = 1'b0;
    winner   = '0;
    candSum  = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      candSum = {1'b0, ptr_q} + SW'(k);
      if (candSum >= SW'(NREQ)) candSum = candSum - SW'(NREQ);
      cand = candSum[PW-1:0];
      if (!anyGrant && req_valid[cand]) begin
        anyGrant = 1'b1;
        winner   = cand;
      end
    end
    if (reset) anyGrant = 1'b0;
  end

  // One-hot grant and next pointer (winner+1 mod NREQ; hold when idle).
  always_comb begin
    req_ready = '0;
    ptr_d     = ptr_q;
    nextSum   = {1'b0, winner} + SW'(1);
    if (nextSum >= SW'(NREQ)) nextSum = '0;
    if (anyGrant) begin
      req_ready[winner] = 1'b1;
      ptr_d             = nextSum[PW-1:0];
    end
  end

  assign winAddr = addrArr[winner];
  assign winData = dataArr[winner];

  // Output stage: register the winner. A grant to r0 still consumes the
  // slot and advances ptr, but never raises the write enable. Address and
  // data hold when idle since they are qualified by rf_write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q           <= '0;
      rf_write_q      <= 1'b0;
      rf_write_addr_q <= '0;
      rf_data_q       <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_write_q <= anyGrant && (winAddr != 5'd0);
      if (anyGrant) begin
        rf_write_addr_q <= winAddr;
        rf_data_q       <= winData;
      end
    end
  end

  // Scoreboard next state. A reservation on a saturated count is dropped
  // and latches the overflow flag. A writeback only decrements a nonzero
  // count, so untracked single-cycle results pass through harmlessly.
  // Simultaneous increment and decrement on one register cancel out.
  always_comb begin
    incVec = '0;
    decVec = '0;
    ovf_d  = ovf_q;
    if (rsv_valid && (rsv_addr != 5'd0)) begin
      if (cnt_q[rsv_addr] == 2'd3) ovf_d = 1'b1;
      else                         incVec[rsv_addr] = 1'b1;
    end
    if (rf_write_q && (rf_write_addr_q != 5'd0) && (cnt_q[rf_write_addr_q] != 2'd0))
      decVec[rf_write_addr_q] = 1'b1;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (incVec[r] && !decVec[r])      cnt_d[r] = cnt_q[r] + 2'd1;
      else if (decVec[r] && !incVec[r]) cnt_d[r] = cnt_q[r] - 2'd1;
    end
    cnt_d[0] = 2'd0;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '{default: 2'd0};
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Hazard reads only the registered counts, so a reservation made this
  // cycle shows up one cycle later. Forced low during reset.
  assign hazard = !reset &&
                  (((chk_addr_a != 5'd0) && (cnt_q[chk_addr_a] != 2'd0)) ||
                   ((chk_addr_b != 5'd0) && (cnt_q[chk_addr_b] != 2'd0)));

  assign rf_write      = rf_write_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_data       = rf_data_q;
  assign rsv_overflow  = ovf_q;

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_reg_wb_scheduler
//
// Directed bench for reg_wb_scheduler (NREQ = 3, DATA_W = 32). A behavioural
// model of the round-robin pointer, output stage and pending-write counts
// predicts req_ready and hazard each cycle; granted writebacks are pushed to
// an expected-write queue and popped when the write port should fire.
// ---------------------------------------------------------------------------
module tb_reg_wb_scheduler;

  localparam int NREQ   = 3;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        reqValid;
  logic [5*NREQ-1:0]      reqAddr;
  logic [DATA_W*NREQ-1:0] reqData;
  logic [NREQ-1:0]        reqReady;
  logic                   rsvValid;
  logic [4:0]             rsvAddr;
  logic [4:0]             chkA;
  logic [4:0]             chkB;
  logic                   hazard;
  logic                   rfWrite;
  logic [4:0]             rfWriteAddr;
  logic [DATA_W-1:0]      rfData;
  logic                   rsvOverflow;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  wbEntry_t   expQ [$];
  int         mPtr;
  logic [1:0] mCnt [32];
  logic       mWr;
  logic [4:0] mWrAddr;
  logic       mOvf;

  reg_wb_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (reqValid),
    .req_addr      (reqAddr),
    .req_data      (reqData),
    .req_ready     (reqReady),
    .rsv_valid     (rsvValid),
    .rsv_addr      (rsvAddr),
    .chk_addr_a    (chkA),
    .chk_addr_b    (chkB),
    .hazard        (hazard),
    .rf_write      (rfWrite),
    .rf_write_addr (rfWriteAddr),
    .rf_data       (rfData),
    .rsv_overflow  (rsvOverflow)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int i, input logic [4:0] a, input logic [DATA_W-1:0] d);
    reqAddr[5*i +: 5]           = a;
    reqData[DATA_W*i +: DATA_W] = d;
  endtask

  // Drives one cycle of inputs (entered just after a falling edge), checks
  // the combinational outputs against the model, advances the model across
  // the rising edge, then checks the registered outputs.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic rv, input logic [4:0] ra,
                               input logic [4:0] ca, input logic [4:0] cb, input logic rst);
    int              g;
    logic [NREQ-1:0] expRdy;
    logic            expHaz;
    logic [4:0]      incR;
    logic [4:0]      decR;
    logic [4:0]      ga;
    logic [DATA_W-1:0] gd;
    wbEntry_t        e;

    reqValid = v;
    rsvValid = rv;
    rsvAddr  = ra;
    chkA     = ca;
    chkB     = cb;
    reset    = rst;
    #1;

    g = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (mPtr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    expRdy = '0;
    if (g >= 0) expRdy[g] = 1'b1;
    checkOutput("req_ready", 64'(reqReady), 64'(expRdy));

    expHaz = !rst && (((ca != 5'd0) && (mCnt[ca] != 2'd0)) || ((cb != 5'd0) && (mCnt[cb] != 2'd0)));
    checkOutput("hazard", 64'(hazard), 64'(expHaz));

    @(posedge clk);
    if (rst) begin
      mCnt    = '{default: 2'd0};
      mPtr    = 0;
      mWr     = 1'b0;
      mWrAddr = 5'd0;
      mOvf    = 1'b0;
      expQ.delete();
    end else begin
      incR = 5'd0;
      decR = 5'd0;
      if (rv && ra != 5'd0) begin
        if (mCnt[ra] == 2'd3) mOvf = 1'b1;
        else                  incR = ra;
      end
      if (mWr && mCnt[mWrAddr] != 2'd0) decR = mWrAddr;
      if (incR != decR) begin
        if (incR != 5'd0) mCnt[incR] = mCnt[incR] + 2'd1;
        if (decR != 5'd0) mCnt[decR] = mCnt[decR] - 2'd1;
      end
      mWr = 1'b0;
      if (g >= 0) begin
        ga   = reqAddr[5*g +: 5];
        gd   = reqData[DATA_W*g +: DATA_W];
        mPtr = (g + 1) % NREQ;
        if (ga != 5'd0) begin
          mWr     = 1'b1;
          mWrAddr = ga;
          e.addr  = ga;
          e.data  = gd;
          expQ.push_back(e);
        end
      end
    end
    #1;

    checkOutput("rf_write", 64'(rfWrite), 64'(mWr));
    if (mWr) begin
      if (expQ.size() == 0) begin
        checkOutput("expq_nonempty", 64'(0), 64'(1));
      end else begin
        e = expQ.pop_front();
        checkOutput("rf_write_addr", 64'(rfWriteAddr), 64'(e.addr));
        checkOutput("rf_data", 64'(rfData), 64'(e.data));
      end
    end
    checkOutput("rsv_overflow", 64'(rsvOverflow), 64'(mOvf));
    @(negedge clk);
  endtask

  initial begin
    reqValid = '0;
    reqAddr  = '0;
    reqData  = '0;
    rsvValid = 1'b0;
    rsvAddr  = '0;
    chkA     = '0;
    chkB     = '0;
    reset    = 1'b1;
    mPtr     = 0;
    mCnt     = '{default: 2'd0};
    mWr      = 1'b0;
    mWrAddr  = 5'd0;
    mOvf     = 1'b0;
    @(negedge clk);

    $display("[TB] reset with requests held, then idle");
    setReq(0, 5'd1, 32'h1111_0001);
    setReq(1, 5'd2, 32'h2222_0002);
    setReq(2, 5'd3, 32'h3333_0003);
    repeat (2) applyStimulus(3'b111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    repeat (5) applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    $display("[TB] round-robin with all requesters valid");
    repeat (6) applyStimulus(3'b111, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    $display("[TB] reserve r8, writeback from requester 2");
    applyStimulus(3'b000, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    repeat (2) applyStimulus(3'b000, 1'b0, 5'd0, 5'd8, 5'd0, 1'b0);
    setReq(2, 5'd8, 32'hDEAD_BEEF);
    applyStimulus(3'b100, 1'b0, 5'd0, 5'd8, 5'd0, 1'b0);
    repeat (2) applyStimulus(3'b000, 1'b0, 5'd0, 5'd8, 5'd0, 1'b0);

    $display("[TB] saturate r5 and drain it");
    repeat (4) applyStimulus(3'b000, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      setReq(0, 5'd5, 32'h5550_0000 + 32'(i));
      applyStimulus(3'b001, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0);
    end
    repeat (3) applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0);

    $display("[TB] reserve r9 on the cycle r9 is written back");
    applyStimulus(3'b000, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    setReq(1, 5'd9, 32'h9999_0001);
    applyStimulus(3'b010, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0);
    applyStimulus(3'b000, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    repeat (2) applyStimulus(3'b000, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0);
    setReq(1, 5'd9, 32'h9999_0002);
    applyStimulus(3'b010, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0);
    repeat (2) applyStimulus(3'b000, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0);

    $display("[TB] writeback to r0, then pointer check");
    setReq(1, 5'd0, 32'h0000_1234);
    applyStimulus(3'b010, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    setReq(0, 5'd12, 32'hC0DE_0012);
    setReq(1, 5'd13, 32'hC0DE_0013);
    setReq(2, 5'd14, 32'hC0DE_0014);
    applyStimulus(3'b111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    $display("[TB] reset during a pending transfer");
    applyStimulus(3'b000, 1'b1, 5'd20, 5'd20, 5'd0, 1'b0);
    applyStimulus(3'b001, 1'b0, 5'd0, 5'd20, 5'd0, 1'b0);
    applyStimulus(3'b111, 1'b0, 5'd0, 5'd20, 5'd0, 1'b1);
    repeat (2) applyStimulus(3'b000, 1'b0, 5'd0, 5'd20, 5'd0, 1'b0);
    repeat (3) applyStimulus(3'b111, 1'b0, 5'd0, 5'd12, 5'd20, 1'b0);
    applyStimulus(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
